// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one single-port RAM between instruction and data caches.
// Command reaches the RAM 1 cycle after grant; ready follows 1 cycle after the stall drops; the loser waits in IDLE.
module ram_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        instReq,
  input  logic [31:0] instAddress,
  output logic        instReady,
  output logic [31:0] instData,

  input  logic        dataReq,
  input  logic        dataWrite,
  input  logic [31:0] dataAddress,
  input  logic [31:0] dataValue,
  output logic        dataReady,
  output logic [31:0] dataData,

  output logic [31:0] ramAddress,
  output logic [31:0] ramValue,
  output logic        ramRead,
  output logic        ramWrite,
  input  logic        ramStall,
  input  logic [31:0] ramData,

  output logic        grantInst,
  output logic        timeoutError
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [16:0] WD_LIMIT = 17'(TIMEOUT);

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] value;
    logic        write;
  } cmd_t;

  logic [1:0]  state;
  cmd_t        cmd;
  logic        lastGrantData;
  logic [15:0] wdCount;
  logic        wdExpire;
  logic        grantI;
  logic        grantD;
  logic        busy;
  logic        finish;

  assign ramAddress = cmd.address;
  assign ramValue   = cmd.value;

  // On a tie the requester that did not win last time gets the RAM.
  always_comb begin
    grantI = 1'b0;
    grantD = 1'b0;
    if (state == IDLE) begin
      if (instReq && (!dataReq || lastGrantData)) begin
        grantI = 1'b1;
      end else if (dataReq) begin
        grantD = 1'b1;
      end
    end
  end

  // Expiry fires on the stalled cycle that brings the count up to TIMEOUT.
  assign busy     = (state == BUSY_I) || (state == BUSY_D);
  assign wdExpire = (TIMEOUT != 0) && ramStall && (({1'b0, wdCount} + 17'd1) >= WD_LIMIT);
  assign finish   = busy && (!ramStall || wdExpire);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cmd           <= '0;
      lastGrantData <= 1'b1;
      wdCount       <= 16'd0;
      ramRead       <= 1'b0;
      ramWrite      <= 1'b0;
      instReady     <= 1'b0;
      dataReady     <= 1'b0;
      instData      <= 32'd0;
      dataData      <= 32'd0;
      grantInst     <= 1'b0;
      timeoutError  <= 1'b0;
    end else begin
      instReady <= 1'b0;
      dataReady <= 1'b0;
      case (state)
        IDLE: begin
          if (grantI) begin
            cmd           <= '{address: instAddress, value: 32'd0, write: 1'b0};
            ramRead       <= 1'b1;
            ramWrite      <= 1'b0;
            grantInst     <= 1'b1;
            lastGrantData <= 1'b0;
            wdCount       <= 16'd0;
            state         <= BUSY_I;
          end else if (grantD) begin
            cmd           <= '{address: dataAddress, value: dataValue, write: dataWrite};
            ramRead       <= !dataWrite;
            ramWrite      <= dataWrite;
            grantInst     <= 1'b0;
            lastGrantData <= 1'b1;
            wdCount       <= 16'd0;
            state         <= BUSY_D;
          end
        end
        BUSY_I, BUSY_D: begin
          if (finish) begin
            ramRead   <= 1'b0;
            ramWrite  <= 1'b0;
            grantInst <= 1'b0;
            state     <= RESP;
            if (ramStall) begin
              timeoutError <= 1'b1;
            end
            // An aborted read returns all ones so the requester sees a poisoned word.
            if (state == BUSY_I) begin
              instReady <= 1'b1;
              instData  <= ramStall ? 32'hFFFF_FFFF : ramData;
            end else begin
              dataReady <= 1'b1;
              if (!cmd.write) begin
                dataData <= ramStall ? 32'hFFFF_FFFF : ramData;
              end
            end
          end else if (wdCount != 16'hFFFF) begin
            wdCount <= wdCount + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed test-plan scenarios then random traffic against a transaction-level model.
module tb_ram_arbiter;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        instReq;
  logic [31:0] instAddress;
  logic        instReady;
  logic [31:0] instData;
  logic        dataReq;
  logic        dataWrite;
  logic [31:0] dataAddress;
  logic [31:0] dataValue;
  logic        dataReady;
  logic [31:0] dataData;
  logic [31:0] ramAddress;
  logic [31:0] ramValue;
  logic        ramRead;
  logic        ramWrite;
  logic        ramStall;
  logic [31:0] ramData;
  logic        grantInst;
  logic        timeoutError;

  ram_arbiter #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .instReq(instReq), .instAddress(instAddress), .instReady(instReady), .instData(instData),
    .dataReq(dataReq), .dataWrite(dataWrite), .dataAddress(dataAddress), .dataValue(dataValue),
    .dataReady(dataReady), .dataData(dataData),
    .ramAddress(ramAddress), .ramValue(ramValue), .ramRead(ramRead), .ramWrite(ramWrite),
    .ramStall(ramStall), .ramData(ramData),
    .grantInst(grantInst), .timeoutError(timeoutError)
  );

  always #5 clock = ~clock;

  int checkCount = 0;
  int errCount   = 0;

  // Requester-side state and reference model.
  bit          iPend, dPend, dWr, lastData;
  logic [31:0] iAddr, dAddr, dVal;
  logic [31:0] mInst, mData;
  bit          mTo;
  bit [31:0]   mem [bit [31:0]];
  int          raiseAt;
  bit          rWr;
  logic [31:0] rAddr, rVal;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkResetVals(input string tag);
    checkVal({tag, ".ramRead"}, ramRead, 0);
    checkVal({tag, ".ramWrite"}, ramWrite, 0);
    checkVal({tag, ".ramAddress"}, ramAddress, 0);
    checkVal({tag, ".ramValue"}, ramValue, 0);
    checkVal({tag, ".instData"}, instData, 0);
    checkVal({tag, ".dataData"}, dataData, 0);
    checkVal({tag, ".ready"}, {instReady, dataReady}, 0);
    checkVal({tag, ".grantInst"}, grantInst, 0);
    checkVal({tag, ".timeoutError"}, timeoutError, 0);
  endtask

  task automatic raiseInst(input logic [31:0] a);
    iPend = 1; iAddr = a;
  endtask

  task automatic raiseData(input bit wr, input logic [31:0] a, input logic [31:0] v);
    dPend = 1; dWr = wr; dAddr = a; dVal = v;
  endtask

  function automatic logic [31:0] pickAddr();
    return 32'h200 + 32'($urandom_range(0, 7)) * 32'd4;
  endfunction

  // One full arbitration round starting in an IDLE cycle, one step past the edge.
  task automatic runTxn(input int stall);
    bit wInst, isRead, abort;
    logic [31:0] a, expRd;
    int lastHigh;
    wInst  = iPend && (!dPend || lastData);
    a      = wInst ? iAddr : dAddr;
    isRead = wInst || !dWr;
    abort  = (TO != 0) && (stall >= TO);
    lastHigh = abort ? TO : stall + 1;
    if (!mem.exists(a)) mem[a] = $urandom;
    expRd = abort ? 32'hFFFF_FFFF : mem[a];
    instReq = iPend; instAddress = iAddr;
    dataReq = dPend; dataWrite = dWr; dataAddress = dAddr; dataValue = dVal;
    @(posedge clock); #1;
    for (int c = 1; c <= lastHigh; c++) begin
      ramStall = (c <= stall);
      ramData  = (c == stall + 1) ? mem[a] : $urandom;
      checkVal("busy.ramRead", ramRead, isRead);
      checkVal("busy.ramWrite", ramWrite, !isRead);
      checkVal("busy.ramAddress", ramAddress, a);
      if (!isRead) checkVal("busy.ramValue", ramValue, dVal);
      checkVal("busy.grantInst", grantInst, wInst);
      checkVal("busy.noReady", {instReady, dataReady}, 0);
      if (c == raiseAt) begin
        raiseData(rWr, rAddr, rVal);
        dataReq = 1; dataWrite = dWr; dataAddress = dAddr; dataValue = dVal;
        raiseAt = 0;
      end
      @(posedge clock); #1;
    end
    ramStall = 0;
    if (isRead) begin
      if (wInst) mInst = expRd; else mData = expRd;
    end else if (!abort) begin
      mem[a] = dVal;
    end
    if (abort) mTo = 1;
    lastData = !wInst;
    checkVal("resp.instReady", instReady, wInst);
    checkVal("resp.dataReady", dataReady, !wInst);
    checkVal("resp.instData", instData, mInst);
    checkVal("resp.dataData", dataData, mData);
    checkVal("resp.timeoutError", timeoutError, mTo);
    checkVal("resp.strobes", {ramRead, ramWrite, grantInst}, 0);
    @(posedge clock); #1;
    checkVal("idle.noReady", {instReady, dataReady}, 0);
    if (wInst) begin iPend = 0; instReq = 0; end
    else begin dPend = 0; dataReq = 0; end
  endtask

  task automatic resetModel();
    lastData = 1; mInst = 0; mData = 0; mTo = 0;
  endtask

  initial begin
    int stall;
    reset = 1; instReq = 0; instAddress = 0; dataReq = 0; dataWrite = 0;
    dataAddress = 0; dataValue = 0; ramStall = 0; ramData = 0;
    iPend = 0; dPend = 0; dWr = 0; iAddr = 0; dAddr = 0; dVal = 0; raiseAt = 0;
    rWr = 0; rAddr = 0; rVal = 0;
    resetModel();
    repeat (3) @(posedge clock);
    #1;
    checkResetVals("reset");
    reset = 0;

    // Both requesters re-raise every round: grants must alternate from inst.
    for (int k = 0; k < 4; k++) begin
      if (!iPend) raiseInst(32'h80 + 32'(k) * 4);
      if (!dPend) raiseData(0, 32'h90 + 32'(k) * 4, 0);
      runTxn(0);
    end
    if (iPend) runTxn(0);
    if (dPend) runTxn(0);

    mem[32'h40] = 32'h1234_5678;
    raiseInst(32'h40);
    runTxn(0);

    raiseData(1, 32'h100, 32'hCAFE_F00D);
    runTxn(0);
    raiseData(0, 32'h100, 0);
    runTxn(1);

    // Data request arrives mid-stall and is served next.
    rWr = 0; rAddr = 32'h140; rVal = 0; raiseAt = 3;
    raiseInst(32'h44);
    runTxn(5);
    runTxn(0);

    raiseInst(32'h48);
    runTxn(TO + 12);
    raiseData(1, 32'h100, 32'h5555_AAAA);
    runTxn(TO);
    raiseData(0, 32'h100, 0);
    runTxn(TO - 1);

    for (int n = 0; n < 40; n++) begin
      if (!iPend && $urandom_range(0, 1) == 1) raiseInst(pickAddr());
      if (!dPend && $urandom_range(0, 1) == 1) raiseData(1'($urandom_range(0, 1)), pickAddr(), $urandom);
      if (!iPend && !dPend) raiseInst(pickAddr());
      stall = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 4);
      runTxn(stall);
    end
    if (iPend) runTxn(0);
    if (dPend) runTxn(0);

    // Reset in the middle of a stalled data read.
    raiseData(0, 32'h300, 0);
    dataReq = 1; dataWrite = 0; dataAddress = 32'h300;
    @(posedge clock); #1;
    ramStall = 1;
    checkVal("rstBusy.ramRead", ramRead, 1);
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
    checkResetVals("midReset");
    reset = 0; ramStall = 0;
    resetModel();
    raiseInst(32'h304);
    runTxn(0);
    runTxn(0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
